serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
//
// PURPOSE
//   Bit-serial adder sequencer. It reuses one 1-bit add cell (two half-adder
//   stages plus an OR for the carry) once per clock to add two WIDTH-bit
//   operands, LSB first.
//   Sits between a requesting master (start/busy/done handshake) and the shared
//   1-bit adder datapath. It trades WIDTH cycles of latency for minimal adder area.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 1..32
//
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      reset, asynchronous, active-low
//   start      in   1      request; sampled only in IDLE or DONE
//   op_a       in   WIDTH  operand A; captured on the accepted start edge
//   op_b       in   WIDTH  operand B; captured on the accepted start edge
//   busy       out  1      high while a sum is being computed
//   done       out  1      one-cycle pulse: result/carry_out valid
//   result     out  WIDTH  op_a + op_b mod 2^WIDTH; held until next accepted start
//   carry_out  out  1      unsigned carry out of the MSB; held with result
//   ovf        out  1      signed overflow (present only with SERIAL_ADD_OVF_EN)
//
// BEHAVIOUR
//   - Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
//     While rst_n=0: state=IDLE, busy=0, done=0, result=0, carry_out=0, ovf=0,
//     bit counter=0, internal carry=0, operand shift registers=0.
//   - FSM states IDLE, RUN, DONE. Registered, Moore outputs: busy=(state==RUN),
//     done=(state==DONE).
//   - IDLE, start=1: capture op_a/op_b into shift regs sa/sb; cnt=0, c=0 -> RUN.
//   - IDLE, start=0: stay in IDLE.
//   - RUN, each edge:
//       s = sa[0]^sb[0]^c
//       c <= (sa[0]&sb[0]) | (c&(sa[0]^sb[0]))
//       sa/sb shift right, zero-filled
//       result shifts right with s inserted at bit WIDTH-1
//       cnt <= cnt+1
//   - RUN, edge where cnt==WIDTH-1: final bit processed; carry_out <= final carry -> DONE.
//   - DONE lasts exactly one cycle. start=1 -> RUN with new operands (back-to-back,
//     no idle gap); else -> IDLE.
//   - Latency: start accepted at edge E0 -> busy=1 after E0 .. EW; done=1 for the
//     cycle after edge E(WIDTH); busy=0 in that same cycle. Throughput: one add per
//     WIDTH+1 cycles.
//   - start while in RUN: ignored; no queueing. op_a/op_b changes during RUN: no effect.
//   - result/carry_out update only during RUN; stable in IDLE/DONE until the next start.
//   - Intermediate result bits during RUN are don't-care to consumers; qualify with done.
//   - Counter width = clog2(WIDTH)+1; never wraps (RUN exits at WIDTH-1).
//   - WIDTH=1: single RUN cycle; done on the second edge after start.
//   - Reset asserted mid-RUN: immediate abort; all outputs return to reset values;
//     no done pulse. After release, the FSM resumes in IDLE.
//
// CONFIGURATION
//   SERIAL_ADD_OVF_EN defined:
//     - ovf port exists.
//     - On the final RUN bit: ovf <= c_in_msb ^ c_out_msb, i.e. signed overflow
//       of the two's-complement add.
//     - Held with result; cleared by reset only.
//   SERIAL_ADD_OVF_EN undefined:
//     - ovf port and its register are absent.
//     - All other behaviour is identical.
//
// TESTING (WIDTH=8)
//   1 a=0x0F, b=0x01, start 1 cycle -> busy 8 cycles; done pulse 1 cycle;
//     result=0x10, carry_out=0.
//   2 a=0xFF, b=0x01 -> result=0x00, carry_out=1, ovf=0; a=0x7F, b=0x01 -> result=0x80,
//     carry_out=0, ovf=1 (OVF_EN build).
//   3 start again at the 3rd busy cycle with a=0x55 -> ignored; result still the
//     first request's sum; only one done pulse.
//   4 start held high through DONE with a=0x10, b=0x20 -> RUN re-entered immediately;
//     second done exactly 9 cycles after the first; result=0x30.
//   5 rst_n low at the 4th busy cycle -> busy=0, done=0, result=0 asynchronously;
//     no done; next add 0x03+0x04 -> 0x07 correct.
//   6 Random 1000 operand pairs, WIDTH=8 and WIDTH=1 -> {carry_out,result}==a+b;
//     done period = WIDTH+1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer adding two WIDTH-bit operands LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             c, s, c_nxt;
  always_comb begin
    s     = sa[0] ^ sb[0] ^ c;
    c_nxt = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
      cnt       <= '0;
      c         <= 1'b0;
      sa        <= '0;
      sb        <= '0;
    end else begin
      case (state)
        RUN: begin
          c      <= c_nxt;
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          result <= (result >> 1) | (WIDTH'(s) << (WIDTH - 1));
          if (cnt == CW'(WIDTH - 1)) begin
            carry_out <= c_nxt;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= c ^ c_nxt;
`endif
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back adds
          if (start) begin
            sa    <= op_a;
            sb    <= op_b;
            cnt   <= '0;
            c     <= 1'b0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
